// File: rtl/accelerator_pkg.sv
// Shared constants and the collector state encoding for the accelerator block family.
// Combinational definitions only; no latency and no flow control of its own.
package accelerator_pkg;

    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;
    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;
    localparam logic        FULL         = 1'b1;
    localparam logic        EMPTY        = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_t;

endpackage

// File: rtl/accelerator_vector_buffer.sv
// MAX_R x DATA_SIZE register file: one write port, one registered read port (1-cycle latency)
// that returns zero for indices at or beyond size_r_i; reads see the pre-write value, no backpressure.
module accelerator_vector_buffer #(
    parameter int DATA_SIZE  = 64,
    parameter int MAX_R      = 16,
    parameter int INDEX_SIZE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [INDEX_SIZE-1:0] wr_index_i,
    input  logic [DATA_SIZE-1:0]  wr_data_i,
    input  logic [INDEX_SIZE-1:0] rd_index_i,
    input  logic [INDEX_SIZE:0]   size_r_i,
    output logic [DATA_SIZE-1:0]  rd_data_o
);

    logic [DATA_SIZE-1:0] mem_q [MAX_R];
    logic [DATA_SIZE-1:0] rd_data_q;
    logic [DATA_SIZE-1:0] rd_data_d;

    // Stale entries past the active vector length are masked rather than cleared.
    assign rd_data_d = ({1'b0, rd_index_i} < size_r_i) ? mem_q[rd_index_i] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_R; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_index_i] <= wr_data_i;
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/accelerator_read_strengths_collector.sv
// Captures beta(t;i), i = 0..R-1, from the read-strength stream into a vector buffer; READY pulses
// one cycle after the last capture, reads are 1-cycle registered; no backpressure, extra beats drop.
module accelerator_read_strengths_collector
    import accelerator_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MAX_R        = 16,
    parameter int INDEX_SIZE   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  READY,
    input  logic                  BETA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]  SIZE_R_IN,
    input  logic [DATA_SIZE-1:0]  BETA_IN,
    input  logic [INDEX_SIZE-1:0] RD_INDEX,
    output logic [DATA_SIZE-1:0]  RD_DATA,
    output logic                  VECTOR_VALID,
    output logic [INDEX_SIZE:0]   COUNT_OUT,
    output logic                  SIZE_ERROR
);

    localparam logic [DATA_SIZE-1:0]  MAX_R_WIDE = DATA_SIZE'(MAX_R);
    localparam logic [INDEX_SIZE:0]   MAX_R_CNT  = (INDEX_SIZE+1)'(MAX_R);

    collector_state_t      state_q;
    logic [INDEX_SIZE:0]   size_r_q;
    logic [INDEX_SIZE:0]   count_q;
    logic                  ready_q;
    logic                  vector_valid_q;
    logic                  size_error_q;

    logic                  oversize;
    logic [INDEX_SIZE:0]   size_r_d;
    logic [INDEX_SIZE:0]   count_d;
    logic                  wr_en;

    // Full-width compare so upper SIZE_R_IN bits can never alias into a small R.
    assign oversize = (SIZE_R_IN > MAX_R_WIDE);
    assign size_r_d = oversize ? MAX_R_CNT : SIZE_R_IN[INDEX_SIZE:0];
    assign count_d  = count_q + 1'b1;
    assign wr_en    = (state_q == COLLECT) && BETA_IN_ENABLE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            size_r_q       <= '0;
            count_q        <= '0;
            ready_q        <= 1'b0;
            vector_valid_q <= 1'b0;
            size_error_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        size_r_q     <= size_r_d;
                        size_error_q <= oversize;
                        count_q      <= '0;
                        if (size_r_d == '0) begin
                            state_q        <= DONE;
                            ready_q        <= 1'b1;
                            vector_valid_q <= 1'b1;
                        end else begin
                            state_q        <= COLLECT;
                            vector_valid_q <= 1'b0;
                        end
                    end
                end
                COLLECT: begin
                    if (BETA_IN_ENABLE) begin
                        count_q <= count_d;
                        if (count_d == size_r_q) begin
                            state_q        <= DONE;
                            ready_q        <= 1'b1;
                            vector_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    accelerator_vector_buffer #(
        .DATA_SIZE  (DATA_SIZE),
        .MAX_R      (MAX_R),
        .INDEX_SIZE (INDEX_SIZE)
    ) u_vector_buffer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .wr_en_i    (wr_en),
        .wr_index_i (count_q[INDEX_SIZE-1:0]),
        .wr_data_i  (BETA_IN),
        .rd_index_i (RD_INDEX),
        .size_r_i   (size_r_q),
        .rd_data_o  (RD_DATA)
    );

    assign READY        = ready_q;
    assign VECTOR_VALID = vector_valid_q;
    assign COUNT_OUT    = count_q;
    assign SIZE_ERROR   = size_error_q;

endmodule

// File: tb/tb_accelerator_read_strengths_collector.sv
// Directed bench: inputs change and outputs are sampled on the falling edge of CLK.
module tb_accelerator_read_strengths_collector;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        READY;
    logic        BETA_IN_ENABLE;
    logic [63:0] SIZE_R_IN;
    logic [63:0] BETA_IN;
    logic [3:0]  RD_INDEX;
    logic [63:0] RD_DATA;
    logic        VECTOR_VALID;
    logic [4:0]  COUNT_OUT;
    logic        SIZE_ERROR;

    int tests_run;
    int tests_failed;

    accelerator_read_strengths_collector #(
        .DATA_SIZE    (64),
        .CONTROL_SIZE (64),
        .MAX_R        (16),
        .INDEX_SIZE   (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .START          (START),
        .READY          (READY),
        .BETA_IN_ENABLE (BETA_IN_ENABLE),
        .SIZE_R_IN      (SIZE_R_IN),
        .BETA_IN        (BETA_IN),
        .RD_INDEX       (RD_INDEX),
        .RD_DATA        (RD_DATA),
        .VECTOR_VALID   (VECTOR_VALID),
        .COUNT_OUT      (COUNT_OUT),
        .SIZE_ERROR     (SIZE_ERROR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0; START = 1'b0; BETA_IN_ENABLE = 1'b0;
        SIZE_R_IN = '0; BETA_IN = '0; RD_INDEX = '0;
        #2 RST = 1'b1;
        tick(); tick();
        tests_run++;
        if (READY !== 1'b0 || VECTOR_VALID !== 1'b0 || SIZE_ERROR !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got ready=%0b vv=%0b se=%0b exp 0 0 0", READY, VECTOR_VALID, SIZE_ERROR);
        end
        tests_run++;
        if (COUNT_OUT !== 5'd0 || RD_DATA !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_data got count=%0d rd=%h exp 0 0", COUNT_OUT, RD_DATA);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic_collect();
        START = 1'b1; SIZE_R_IN = 64'd4;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            BETA_IN_ENABLE = 1'b1; BETA_IN = 64'h10 + 64'(i);
            tick();
            if (i < 3) begin
                tests_run++;
                if (READY !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL basic_early_ready beat=%0d got %0b exp 0", i, READY);
                end
            end
        end
        tests_run++;
        if (READY !== 1'b1 || VECTOR_VALID !== 1'b1 || COUNT_OUT !== 5'd4) begin
            tests_failed++;
            $display("FAIL basic_done got ready=%0b vv=%0b count=%0d exp 1 1 4", READY, VECTOR_VALID, COUNT_OUT);
        end
        BETA_IN_ENABLE = 1'b0; RD_INDEX = 4'd2;
        tick();
        tests_run++;
        if (RD_DATA !== 64'h12 || READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_read got rd=%h ready=%0b exp 12 0", RD_DATA, READY);
        end
    endtask

    task automatic test_gapped_input();
        int gaps [3] = '{0, 2, 5};
        START = 1'b1; SIZE_R_IN = 64'd3;
        tick();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                START = (g == 0);
                tick();
                START = 1'b0;
                tests_run++;
                if (READY !== 1'b0 || COUNT_OUT !== 5'(i)) begin
                    tests_failed++;
                    $display("FAIL gap_idle beat=%0d got ready=%0b count=%0d exp 0 %0d", i, READY, COUNT_OUT, i);
                end
            end
            BETA_IN_ENABLE = 1'b1; BETA_IN = 64'h21 + 64'(i);
            tick();
            BETA_IN_ENABLE = 1'b0;
        end
        tests_run++;
        if (READY !== 1'b1 || COUNT_OUT !== 5'd3) begin
            tests_failed++;
            $display("FAIL gap_done got ready=%0b count=%0d exp 1 3", READY, COUNT_OUT);
        end
        for (int i = 0; i < 3; i++) begin
            RD_INDEX = 4'(i);
            tick();
            tests_run++;
            if (RD_DATA !== 64'h21 + 64'(i)) begin
                tests_failed++;
                $display("FAIL gap_read idx=%0d got %h exp %h", i, RD_DATA, 64'h21 + 64'(i));
            end
        end
    endtask

    task automatic test_zero_and_oversize();
        START = 1'b1; SIZE_R_IN = 64'd0;
        tick();
        START = 1'b0;
        tests_run++;
        if (READY !== 1'b1 || COUNT_OUT !== 5'd0 || VECTOR_VALID !== 1'b1 || SIZE_ERROR !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done got ready=%0b count=%0d vv=%0b se=%0b exp 1 0 1 0",
                     READY, COUNT_OUT, VECTOR_VALID, SIZE_ERROR);
        end
        for (int i = 0; i < 3; i++) begin
            RD_INDEX = 4'(i);
            tick();
            tests_run++;
            if (RD_DATA !== 64'd0) begin
                tests_failed++;
                $display("FAIL zero_read idx=%0d got %h exp 0", i, RD_DATA);
            end
        end

        START = 1'b1; SIZE_R_IN = 64'd20;
        tick();
        START = 1'b0;
        tests_run++;
        if (SIZE_ERROR !== 1'b1 || VECTOR_VALID !== 1'b0 || COUNT_OUT !== 5'd0) begin
            tests_failed++;
            $display("FAIL over_start got se=%0b vv=%0b count=%0d exp 1 0 0", SIZE_ERROR, VECTOR_VALID, COUNT_OUT);
        end
        for (int i = 0; i < 16; i++) begin
            BETA_IN_ENABLE = 1'b1; BETA_IN = 64'h100 + 64'(i);
            tick();
            if (i == 14) begin
                tests_run++;
                if (READY !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL over_early_ready got %0b exp 0", READY);
                end
            end
        end
        tests_run++;
        if (READY !== 1'b1 || COUNT_OUT !== 5'd16) begin
            tests_failed++;
            $display("FAIL over_done got ready=%0b count=%0d exp 1 16", READY, COUNT_OUT);
        end
        BETA_IN = 64'hDEAD;
        tick();
        tick();
        BETA_IN_ENABLE = 1'b0;
        tests_run++;
        if (COUNT_OUT !== 5'd16 || SIZE_ERROR !== 1'b1) begin
            tests_failed++;
            $display("FAIL over_extra got count=%0d se=%0b exp 16 1", COUNT_OUT, SIZE_ERROR);
        end
        RD_INDEX = 4'd15;
        tick();
        tests_run++;
        if (RD_DATA !== 64'h10F) begin
            tests_failed++;
            $display("FAIL over_read15 got %h exp 10f", RD_DATA);
        end
        RD_INDEX = 4'd0;
        tick();
        tests_run++;
        if (RD_DATA !== 64'h100) begin
            tests_failed++;
            $display("FAIL over_read0 got %h exp 100", RD_DATA);
        end
    endtask

    task automatic test_stale_masking();
        START = 1'b1; SIZE_R_IN = 64'd4;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            BETA_IN_ENABLE = 1'b1; BETA_IN = 64'hA0 + 64'(i);
            tick();
        end
        BETA_IN_ENABLE = 1'b0;
        tick();
        START = 1'b1; SIZE_R_IN = 64'd2;
        tick();
        START = 1'b0;
        tests_run++;
        if (SIZE_ERROR !== 1'b0) begin
            tests_failed++;
            $display("FAIL stale_se got %0b exp 0", SIZE_ERROR);
        end
        for (int i = 0; i < 2; i++) begin
            BETA_IN_ENABLE = 1'b1; BETA_IN = 64'hB0 + 64'(i);
            tick();
        end
        BETA_IN_ENABLE = 1'b0;
        RD_INDEX = 4'd3;
        tick();
        tests_run++;
        if (RD_DATA !== 64'd0) begin
            tests_failed++;
            $display("FAIL stale_read3 got %h exp 0", RD_DATA);
        end
        RD_INDEX = 4'd1;
        tick();
        tests_run++;
        if (RD_DATA !== 64'hB1) begin
            tests_failed++;
            $display("FAIL stale_read1 got %h exp b1", RD_DATA);
        end
    endtask

    task automatic test_reset_mid_collect();
        START = 1'b1; SIZE_R_IN = 64'd4;
        tick();
        START = 1'b0;
        BETA_IN_ENABLE = 1'b1; BETA_IN = 64'hC0;
        tick();
        BETA_IN = 64'hC1; RD_INDEX = 4'd0;
        tick();
        BETA_IN_ENABLE = 1'b0;
        tests_run++;
        if (COUNT_OUT !== 5'd2 || RD_DATA !== 64'hC0) begin
            tests_failed++;
            $display("FAIL mid_partial got count=%0d rd=%h exp 2 c0", COUNT_OUT, RD_DATA);
        end
        #1 RST = 1'b1;
        #1;
        tests_run++;
        if (COUNT_OUT !== 5'd0 || RD_DATA !== 64'd0 || VECTOR_VALID !== 1'b0 || READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got count=%0d rd=%h vv=%0b ready=%0b exp 0 0 0 0",
                     COUNT_OUT, RD_DATA, VECTOR_VALID, READY);
        end
        tick();
        RST = 1'b0;
        tick();
        START = 1'b1; SIZE_R_IN = 64'd1;
        tick();
        START = 1'b0;
        BETA_IN_ENABLE = 1'b1; BETA_IN = 64'h55;
        tick();
        BETA_IN_ENABLE = 1'b0;
        tests_run++;
        if (READY !== 1'b1 || COUNT_OUT !== 5'd1) begin
            tests_failed++;
            $display("FAIL mid_fresh_done got ready=%0b count=%0d exp 1 1", READY, COUNT_OUT);
        end
        RD_INDEX = 4'd0;
        tick();
        tests_run++;
        if (RD_DATA !== 64'h55) begin
            tests_failed++;
            $display("FAIL mid_fresh_read got %h exp 55", RD_DATA);
        end
    endtask

    task automatic test_back_to_back();
        START = 1'b1; SIZE_R_IN = 64'd1;
        tick();
        START = 1'b0;
        BETA_IN_ENABLE = 1'b1; BETA_IN = 64'h66;
        tick();
        BETA_IN_ENABLE = 1'b0;
        tests_run++;
        if (READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready got %0b exp 1", READY);
        end
        START = 1'b1; SIZE_R_IN = 64'd2;
        tick();
        tests_run++;
        if (VECTOR_VALID !== 1'b1 || COUNT_OUT !== 5'd1 || READY !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_start_in_done got vv=%0b count=%0d ready=%0b exp 1 1 0",
                     VECTOR_VALID, COUNT_OUT, READY);
        end
        tick();
        START = 1'b0;
        tests_run++;
        if (VECTOR_VALID !== 1'b0 || COUNT_OUT !== 5'd0) begin
            tests_failed++;
            $display("FAIL b2b_start_after got vv=%0b count=%0d exp 0 0", VECTOR_VALID, COUNT_OUT);
        end
        for (int i = 0; i < 2; i++) begin
            BETA_IN_ENABLE = 1'b1; BETA_IN = 64'h77 + 64'(i);
            tick();
        end
        BETA_IN_ENABLE = 1'b0;
        tests_run++;
        if (READY !== 1'b1 || COUNT_OUT !== 5'd2) begin
            tests_failed++;
            $display("FAIL b2b_done got ready=%0b count=%0d exp 1 2", READY, COUNT_OUT);
        end
        RD_INDEX = 4'd1;
        tick();
        tests_run++;
        if (RD_DATA !== 64'h78) begin
            tests_failed++;
            $display("FAIL b2b_read got %h exp 78", RD_DATA);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_collect();
        test_gapped_input();
        test_zero_and_oversize();
        test_stale_masking();
        test_reset_mid_collect();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
